// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern generator: mode encodings,
// colour constants, default raster size and the box axis step helper.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 600;
  localparam int BOX_SIZE_DEF = 64;
  localparam int BAR_WIDTH    = 100;
  localparam int NUM_BARS     = 8;

  localparam logic [15:0] BOX_STEP = 16'd2;

  typedef enum logic [1:0] {
    MODE_BARS     = 2'b00,
    MODE_CHECKER  = 2'b01,
    MODE_GRADIENT = 2'b10,
    MODE_BOX      = 2'b11
  } mode_e;

  localparam logic [15:0] COLOUR_WHITE = 16'hFFFF;
  localparam logic [15:0] COLOUR_BLACK = 16'h0000;
  localparam logic [15:0] BOX_FG       = 16'hF800;
  localparam logic [15:0] BOX_BG       = 16'h001F;

  // One axis of the bouncing box: current direction and position.
  typedef struct packed {
    logic        fwd;
    logic [15:0] pos;
  } axis_t;

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  // Bounce at the far limit or at zero, otherwise keep stepping.
  function automatic axis_t axis_step(input logic [15:0] pos,
                                      input logic        fwd,
                                      input logic [15:0] limit);
    axis_t r;
    r.fwd = fwd;
    r.pos = pos;
    if (fwd) begin
      if (pos >= limit) begin
        r.fwd = 1'b0;
        r.pos = pos - BOX_STEP;
      end else begin
        r.pos = pos + BOX_STEP;
      end
    end else begin
      if (pos < BOX_STEP) begin
        r.fwd = 1'b1;
        r.pos = pos + BOX_STEP;
      end else begin
        r.pos = pos - BOX_STEP;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position tracker; moves one step per axis on each step pulse.
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int BOX_SIZE = BOX_SIZE_DEF,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic          step,
  output logic [XW-1:0] bx,
  output logic [YW-1:0] by
);

  localparam logic [15:0] X_LIMIT = 16'(H_ACTIVE - BOX_SIZE);
  localparam logic [15:0] Y_LIMIT = 16'(V_ACTIVE - BOX_SIZE);

  logic [XW-1:0] bx_reg, bx_next;
  logic [YW-1:0] by_reg, by_next;
  logic          right_reg, right_next;
  logic          down_reg, down_next;
  axis_t         ax, ay;

  always_comb begin
    ax         = axis_step(16'(bx_reg), right_reg, X_LIMIT);
    ay         = axis_step(16'(by_reg), down_reg, Y_LIMIT);
    bx_next    = ax.pos[XW-1:0];
    by_next    = ay.pos[YW-1:0];
    right_next = ax.fwd;
    down_next  = ay.fwd;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      bx_reg    <= '0;
      by_reg    <= '0;
      right_reg <= 1'b1;
      down_reg  <= 1'b1;
    end else if (step) begin
      bx_reg    <= bx_next;
      by_reg    <= by_next;
      right_reg <= right_next;
      down_reg  <= down_next;
    end
  end

  assign bx = bx_reg;
  assign by = by_reg;

endmodule

// File: rtl/vga_pattern_gen.sv
// Raster-order RGB565 test-pattern source: bars, checker, gradient or a
// bouncing box, one registered pixel per downstream request.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int BOX_SIZE = BOX_SIZE_DEF
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic [1:0]  mode_sel,
  output logic [15:0] data,
  output logic        frame_done
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  logic [XW-1:0] x_reg, x_next;
  logic [YW-1:0] y_reg, y_next;
  mode_e         mode_reg;
  logic [15:0]   data_reg, data_next;
  logic          frame_done_reg;
  logic          last_x, last_y, wrap;

  logic [XW-1:0] bx;
  logic [YW-1:0] by;
  logic [15:0]   x_ext, y_ext, bx_ext, by_ext;
  logic [7:1]    bar_ge;
  logic [2:0]    bar_idx;
  logic          in_box;

  assign last_x = (x_reg == XW'(H_ACTIVE - 1));
  assign last_y = (y_reg == YW'(V_ACTIVE - 1));
  assign wrap   = data_req && last_x && last_y;

  always_comb begin
    x_next = x_reg + XW'(1);
    y_next = y_reg;
    if (last_x) begin
      x_next = '0;
      y_next = last_y ? '0 : y_reg + YW'(1);
    end
  end

  // Box advances on the wrap request, so the next frame's first pixel sees it.
  vga_box_mover #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE),
    .BOX_SIZE(BOX_SIZE),
    .XW      (XW),
    .YW      (YW)
  ) u_box (
    .sys_clk(sys_clk),
    .rst    (rst),
    .step   (wrap),
    .bx     (bx),
    .by     (by)
  );

  assign x_ext  = 16'(x_reg);
  assign y_ext  = 16'(y_reg);
  assign bx_ext = 16'(bx);
  assign by_ext = 16'(by);

  genvar gi;
  generate
    for (gi = 1; gi < NUM_BARS; gi++) begin : g_bar
      assign bar_ge[gi] = (x_ext >= 16'(gi * BAR_WIDTH));
    end
  endgenerate

  // Thermometer of bar boundaries passed gives the bar index without a divider.
  always_comb begin
    bar_idx = '0;
    for (int i = 1; i < NUM_BARS; i++) begin
      bar_idx = bar_idx + 3'(bar_ge[i]);
    end
  end

  assign in_box = (x_ext >= bx_ext) && (x_ext < bx_ext + 16'(BOX_SIZE)) &&
                  (y_ext >= by_ext) && (y_ext < by_ext + 16'(BOX_SIZE));

  always_comb begin
    data_next = COLOUR_BLACK;
    case (mode_reg)
      MODE_BARS:     data_next = bar_colour(bar_idx);
      MODE_CHECKER:  data_next = (x_ext[5] ^ y_ext[5]) ? COLOUR_WHITE : COLOUR_BLACK;
      MODE_GRADIENT: data_next = {x_ext[9:5], y_ext[9:4], 5'b0};
      MODE_BOX:      data_next = in_box ? BOX_FG : BOX_BG;
      default:       data_next = COLOUR_BLACK;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      x_reg          <= '0;
      y_reg          <= '0;
      mode_reg       <= MODE_BARS;
      data_reg       <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= wrap;
      if (data_req) begin
        data_reg <= data_next;
        x_reg    <= x_next;
        y_reg    <= y_next;
      end
      if (wrap) begin
        mode_reg <= mode_e'(mode_sel);
      end
    end
  end

  assign data       = data_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench: three differently sized generators share one clock; every
// request is checked against a behavioural model plus hand-computed probes.
module tb_vga_pattern_gen;

  localparam int HS [3] = '{800, 64, 16};
  localparam int VS [3] = '{2, 48, 12};
  localparam int BS [3] = '{64, 8, 4};

  logic             clk = 1'b0;
  logic [2:0]       rst_v;
  logic [2:0]       req_v;
  logic [2:0][1:0]  mode_v;
  logic [2:0][15:0] data_v;
  logic [2:0]       fd_v;

  always #5 clk = ~clk;

  vga_pattern_gen #(.H_ACTIVE(800), .V_ACTIVE(2), .BOX_SIZE(64)) dut0 (
    .sys_clk(clk), .rst(rst_v[0]), .data_req(req_v[0]), .mode_sel(mode_v[0]),
    .data(data_v[0]), .frame_done(fd_v[0]));
  vga_pattern_gen #(.H_ACTIVE(64), .V_ACTIVE(48), .BOX_SIZE(8)) dut1 (
    .sys_clk(clk), .rst(rst_v[1]), .data_req(req_v[1]), .mode_sel(mode_v[1]),
    .data(data_v[1]), .frame_done(fd_v[1]));
  vga_pattern_gen #(.H_ACTIVE(16), .V_ACTIVE(12), .BOX_SIZE(4)) dut2 (
    .sys_clk(clk), .rst(rst_v[2]), .data_req(req_v[2]), .mode_sel(mode_v[2]),
    .data(data_v[2]), .frame_done(fd_v[2]));

  typedef struct {
    int          d;
    int          f;
    int          x;
    int          y;
    logic [15:0] exp_v;
  } probe_t;

  probe_t      probes[$];
  logic [15:0] bars [8];
  int          px[3], py[3], fcnt[3], fmode[3], bxm[3], bym[3];
  bit          rdir[3], ddir[3];
  logic [15:0] last_exp[3];
  int          total = 0;
  int          passed = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
    total++;
    if (act === exp_v) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
  endtask

  function automatic logic [15:0] exp_pix(input int d, input int x, input int y);
    int i;
    logic [15:0] r;
    r = 16'h0000;
    case (fmode[d])
      0: begin
        i = x / 100;
        if (i > 7) i = 7;
        r = bars[i];
      end
      1: r = (((x / 32) + (y / 32)) % 2 == 1) ? 16'hFFFF : 16'h0000;
      2: r = 16'(((x / 32) % 32) * 2048 + ((y / 16) % 64) * 32);
      default: r = (x >= bxm[d] && x < bxm[d] + BS[d] && y >= bym[d] && y < bym[d] + BS[d])
                   ? 16'hF800 : 16'h001F;
    endcase
    return r;
  endfunction

  task automatic model_reset(input int d);
    px[d] = 0; py[d] = 0; fmode[d] = 0;
    bxm[d] = 0; bym[d] = 0; rdir[d] = 1; ddir[d] = 1;
    last_exp[d] = 16'h0000;
  endtask

  task automatic box_update(input int d);
    if (rdir[d]) begin
      if (bxm[d] == HS[d] - BS[d]) begin rdir[d] = 0; bxm[d] -= 2; end
      else bxm[d] += 2;
    end else begin
      if (bxm[d] == 0) begin rdir[d] = 1; bxm[d] += 2; end
      else bxm[d] -= 2;
    end
    if (ddir[d]) begin
      if (bym[d] == VS[d] - BS[d]) begin ddir[d] = 0; bym[d] -= 2; end
      else bym[d] += 2;
    end else begin
      if (bym[d] == 0) begin ddir[d] = 1; bym[d] += 2; end
      else bym[d] -= 2;
    end
  endtask

  // One request cycle; leaves data_req high so back-to-back calls stream.
  task automatic do_req(input int d);
    logic [15:0] e;
    logic        efd;
    string       tag;
    req_v[d] = 1'b1;
    tick();
    e   = exp_pix(d, px[d], py[d]);
    efd = (px[d] == HS[d] - 1) && (py[d] == VS[d] - 1);
    tag = $sformatf("dut%0d f%0d (%0d,%0d)", d, fcnt[d], px[d], py[d]);
    check({tag, " data"}, data_v[d], e);
    check({tag, " frame_done"}, {15'b0, fd_v[d]}, {15'b0, efd});
    last_exp[d] = e;
    foreach (probes[i]) begin
      if (probes[i].d == d && probes[i].f == fcnt[d] && probes[i].x == px[d] && probes[i].y == py[d]) begin
        check({tag, " probe"}, data_v[d], probes[i].exp_v);
        $display("vec dut%0d frame %0d pixel (%0d,%0d) data=%h want=%h",
                 d, fcnt[d], px[d], py[d], data_v[d], probes[i].exp_v);
      end
    end
    if (px[d] == HS[d] - 1) begin
      px[d] = 0;
      if (py[d] == VS[d] - 1) begin
        py[d] = 0;
        fcnt[d]++;
        fmode[d] = int'(mode_v[d]);
        box_update(d);
      end else begin
        py[d]++;
      end
    end else begin
      px[d]++;
    end
  endtask

  task automatic idle(input int d);
    req_v[d] = 1'b0;
    tick();
    check($sformatf("dut%0d idle hold", d), data_v[d], last_exp[d]);
    check($sformatf("dut%0d idle frame_done", d), {15'b0, fd_v[d]}, 16'h0000);
  endtask

  initial begin
    #3000000;
    $display("FAIL timeout: bench did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    // Bars on the 800-wide generator, line 0.
    probes.push_back('{0, 0,   0, 0, 16'hFFFF});
    probes.push_back('{0, 0,  99, 0, 16'hFFFF});
    probes.push_back('{0, 0, 100, 0, 16'hFFE0});
    probes.push_back('{0, 0, 250, 0, 16'h07FF});
    probes.push_back('{0, 0, 399, 0, 16'h07E0});
    probes.push_back('{0, 0, 400, 0, 16'hF81F});
    probes.push_back('{0, 0, 550, 0, 16'hF800});
    probes.push_back('{0, 0, 650, 0, 16'h001F});
    probes.push_back('{0, 0, 799, 0, 16'h0000});
    // Frame 0 must still be bars although checker is requested from reset.
    probes.push_back('{1, 0, 10, 10, 16'hFFFF});
    probes.push_back('{1, 1, 31,  0, 16'h0000});
    probes.push_back('{1, 1, 32,  0, 16'hFFFF});
    probes.push_back('{1, 1, 32, 32, 16'h0000});
    probes.push_back('{1, 1,  0, 47, 16'hFFFF});
    probes.push_back('{1, 1, 63, 47, 16'h0000});
    probes.push_back('{1, 2, 40, 20, 16'h0820});
    probes.push_back('{1, 2, 63, 47, 16'h0840});
    // Bouncing box on the 16x12 generator, box edge 4.
    probes.push_back('{2, 1,  2, 2, 16'hF800});
    probes.push_back('{2, 1,  6, 2, 16'h001F});
    probes.push_back('{2, 6, 12, 4, 16'hF800});
    probes.push_back('{2, 6, 11, 4, 16'h001F});
    probes.push_back('{2, 6, 15, 7, 16'hF800});
    probes.push_back('{2, 6, 12, 8, 16'h001F});
    probes.push_back('{2, 7, 10, 2, 16'hF800});
    probes.push_back('{2, 7, 14, 2, 16'h001F});
    probes.push_back('{2, 7,  9, 2, 16'h001F});
    probes.push_back('{2, 7, 13, 5, 16'hF800});

    // Reset with requests held high: requests must be ignored.
    rst_v = 3'b111;
    req_v = 3'b111;
    mode_v[0] = 2'b00; mode_v[1] = 2'b01; mode_v[2] = 2'b11;
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("dut%0d reset data", d), data_v[d], 16'h0000);
      check($sformatf("dut%0d reset frame_done", d), {15'b0, fd_v[d]}, 16'h0000);
      model_reset(d);
      fcnt[d] = 0;
    end
    rst_v = 3'b000;
    req_v = 3'b000;
    tick();
    for (int d = 0; d < 3; d++)
      check($sformatf("dut%0d post-reset idle", d), data_v[d], 16'h0000);

    // dut0: full bar line, then reset mid-frame at (100,1) with req held.
    for (int i = 0; i < 900; i++) do_req(0);
    rst_v[0] = 1'b1;
    req_v[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("dut0 mid-frame reset data", data_v[0], 16'h0000);
      check("dut0 mid-frame reset frame_done", {15'b0, fd_v[0]}, 16'h0000);
    end
    rst_v[0] = 1'b0;
    model_reset(0);
    for (int i = 0; i < 1600; i++) do_req(0);
    idle(0);

    // dut1: bars, checker with a mid-frame mode change, then gradient.
    while (fcnt[1] < 3) begin
      if (fcnt[1] == 1 && px[1] == 32 && py[1] == 24) mode_v[1] = 2'b10;
      if ($urandom_range(0, 15) == 0) idle(1);
      do_req(1);
    end
    idle(1);

    // dut2: eight frames of the bouncing box.
    while (fcnt[2] < 8) do_req(2);
    idle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
